// File: rtl/des_sbox_sequencer.sv
// Walks one 48-bit DES round word through the shared S-box bank, one 6-bit chunk per cycle,
// and assembles the 32-bit substitution result. Define DES_SBOX_SEQ_PIPE_EN for a registered bank.
module des_sbox_sequencer #(
  parameter int NUM_SBOX   = 8,
  parameter int SBOX_IN_W  = 6,
  parameter int SBOX_OUT_W = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:NUM_SBOX*SBOX_IN_W]    in_data,
  output logic                           sbox_req,
  output logic [1:4]                     sbox_sel,
  output logic [1:SBOX_IN_W]             sbox_in,
  input  logic [1:SBOX_OUT_W]            sbox_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [1:NUM_SBOX*SBOX_OUT_W]   out_data,
  output logic                           busy
);

  // state | meaning
  // IDLE  | in_ready high, waiting for an upstream word
  // RUN   | issuing lookups idx 1..8 (plus one drain cycle with a registered bank)
  // DONE  | out_valid high, holding out_data until downstream accepts
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LAST = 4'(NUM_SBOX);

  state_t                        state;
  logic [3:0]                    idx;
  logic [1:NUM_SBOX*SBOX_IN_W]   data_q;
  logic                          bad_state;
`ifdef DES_SBOX_SEQ_PIPE_EN
  logic [3:0]                    pend;
`endif

  assign sbox_sel = idx;

  function automatic logic [1:SBOX_IN_W] chunk_at(input logic [1:NUM_SBOX*SBOX_IN_W] d,
                                                  input logic [3:0] i);
    chunk_at = '0;
    for (int k = 1; k <= NUM_SBOX; k++)
      if (i == 4'(k)) chunk_at = d[SBOX_IN_W*(k-1)+1 +: SBOX_IN_W];
  endfunction

  function automatic logic [1:NUM_SBOX*SBOX_OUT_W] put_nib(input logic [1:NUM_SBOX*SBOX_OUT_W] v,
                                                           input logic [3:0] i,
                                                           input logic [1:SBOX_OUT_W] n);
    put_nib = v;
    for (int k = 1; k <= NUM_SBOX; k++)
      if (i == 4'(k)) put_nib[SBOX_OUT_W*(k-1)+1 +: SBOX_OUT_W] = n;
  endfunction

  // Any corrupted state or index drops straight back to IDLE without presenting output.
  always_comb begin
    bad_state = 1'b0;
    if (!(state inside {IDLE, RUN, DONE})) bad_state = 1'b1;
`ifdef DES_SBOX_SEQ_PIPE_EN
    if (state == RUN && (idx > LAST || pend > LAST || (idx == 4'd0 && pend != LAST)))
      bad_state = 1'b1;
`else
    if (state == RUN && (idx == 4'd0 || idx > LAST)) bad_state = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      sbox_req  <= 1'b0;
      idx       <= '0;
      sbox_in   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      data_q    <= '0;
`ifdef DES_SBOX_SEQ_PIPE_EN
      pend      <= '0;
`endif
    end else if (bad_state) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      sbox_req  <= 1'b0;
      idx       <= '0;
      sbox_in   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          sbox_req  <= 1'b0;
          idx       <= '0;
          sbox_in   <= '0;
          out_valid <= 1'b0;
          if (in_valid && in_ready) begin
            data_q   <= in_data;
            idx      <= 4'd1;
            sbox_in  <= in_data[1:SBOX_IN_W];
            sbox_req <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
`ifdef DES_SBOX_SEQ_PIPE_EN
            pend     <= '0;
`endif
          end
        end
        RUN: begin
`ifdef DES_SBOX_SEQ_PIPE_EN
          // Result on sbox_out belongs to the lookup issued one cycle earlier.
          out_data <= put_nib(out_data, pend, sbox_out);
          pend     <= idx;
          if (idx == 4'd0) begin
            pend      <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (idx == LAST) begin
            idx      <= '0;
            sbox_req <= 1'b0;
            sbox_in  <= '0;
          end else begin
            idx     <= idx + 4'd1;
            sbox_in <= chunk_at(data_q, idx + 4'd1);
          end
`else
          out_data <= put_nib(out_data, idx, sbox_out);
          if (idx == LAST) begin
            idx       <= '0;
            sbox_req  <= 1'b0;
            sbox_in   <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx     <= idx + 4'd1;
            sbox_in <= chunk_at(data_q, idx + 4'd1);
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Randomized bench for des_sbox_sequencer: DES S-box bank model plus a word-level reference
// that computes the full substitution directly from the eight standard tables.
module tb_des_sbox_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, sbox_req, out_valid, out_ready, busy;
  logic [1:48] in_data;
  logic [1:4]  sbox_sel;
  logic [1:6]  sbox_in;
  logic [1:4]  sbox_out;
  logic [1:32] out_data;

  int checks = 0;
  int errors = 0;

`ifdef DES_SBOX_SEQ_PIPE_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  always #5 clk = ~clk;

  des_sbox_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sbox_req(sbox_req), .sbox_sel(sbox_sel), .sbox_in(sbox_in), .sbox_out(sbox_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  int sbox_tab [0:7][0:63] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  // Row is the outer bit pair, column the inner four bits; sel 0 reads as zero.
  function automatic logic [3:0] sbox_f(input logic [3:0] sel, input logic [5:0] x);
    int row, col;
    if (sel < 4'd1 || sel > 4'd8) return 4'h0;
    row = int'({x[5], x[0]});
    col = int'(x[4:1]);
    return 4'(sbox_tab[int'(sel) - 1][row*16 + col]);
  endfunction

  function automatic logic [5:0] chunk_of(input logic [47:0] d, input int k);
    return 6'(d >> (48 - 6*k));
  endfunction

  function automatic logic [31:0] model(input logic [47:0] d);
    logic [31:0] r = '0;
    for (int k = 1; k <= 8; k++)
      r |= 32'(sbox_f(4'(k), chunk_of(d, k))) << (32 - 4*k);
    return r;
  endfunction

`ifdef DES_SBOX_SEQ_PIPE_EN
  initial sbox_out = '0;
  always @(posedge clk) sbox_out <= sbox_f(sbox_sel, sbox_in);
`else
  always_comb sbox_out = sbox_f(sbox_sel, sbox_in);
`endif

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the output handshake edge.
  task automatic do_word(input logic [47:0] d, input int stall, input bit poke);
    int lat;
    logic [31:0] exp;
    exp = model(d);
    out_ready = (stall == 0);
    check_val("rdy_idle", in_ready, 1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~d;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat < 8) begin
        check_val("sel", sbox_sel, lat + 1);
        check_val("sbox_in", sbox_in, chunk_of(d, lat + 1));
        check_val("rdy_run", in_ready, 0);
        check_val("busy_run", busy, 1);
      end
      if (poke) begin
        in_valid = (lat == 2);
        in_data  = ~d;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check_val("latency", lat, LAT);
    check_val("out_data", out_data, exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check_val("stall_valid", out_valid, 1);
      check_val("stall_data", out_data, exp);
      check_val("stall_rdy", in_ready, 0);
      check_val("stall_req", sbox_req, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("valid_drop", out_valid, 0);
    check_val("rdy_after", in_ready, 1);
    check_val("data_hold", out_data, exp);
  endtask

  initial begin
    int n, seen;
    logic [47:0] d;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rdy", in_ready, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_req", sbox_req, 0);
    check_val("rst_sel", sbox_sel, 0);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_data", out_data, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check_val("rdy_pre_edge", in_ready, 0);
    @(posedge clk); #1;
    check_val("rdy_first_edge", in_ready, 1);

    do_word(48'h0, 0, 0);
    check_val("zeros_const", out_data, 32'hEFA72C4D);
    do_word(48'hFFFF_FFFF_FFFF, 0, 0);
    check_val("ones_const", out_data, 32'hD9CE3DCB);
    do_word({16'($urandom), 32'($urandom)}, 5, 0);
    do_word({16'($urandom), 32'($urandom)}, 0, 1);

    // Abort a word at idx 4 with an asynchronous reset.
    d = {16'($urandom), 32'($urandom)};
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (sbox_sel != 4'd4 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("mid_sel", sbox_sel, 4);
    rst_n = 1'b0;
    #1;
    check_val("mid_rdy", in_ready, 0);
    check_val("mid_busy", busy, 0);
    check_val("mid_req", sbox_req, 0);
    check_val("mid_sel0", sbox_sel, 0);
    check_val("mid_sin", sbox_in, 0);
    check_val("mid_valid", out_valid, 0);
    check_val("mid_data", out_data, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("mid_rdy_rel", in_ready, 1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_val("no_partial", seen, 0);
    do_word(48'h0, 0, 0);
    check_val("zeros_after_rst", out_data, 32'hEFA72C4D);

    for (int i = 0; i < 8; i++)
      do_word({16'($urandom), 32'($urandom)}, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_sbox_sequencer.md
Name: des_sbox_sequencer

Overview:
- Sequences one 48-bit DES round-function word through the shared S-box bank, one 6-bit lookup per cycle.
- Assembles the eight 4-bit results into the 32-bit substitution output for the P-permutation stage.
- Sits between the key-XOR stage (upstream, valid/ready) and the permutation stage (downstream, valid/ready).
- Owns the S-box bank select, so only one S-box is active per cycle.

Parameters:
- NUM_SBOX, 8, number of S-boxes and lookups per word; fixed at 8 for DES.
- SBOX_IN_W, 6, width of each S-box input chunk.
- SBOX_OUT_W, 4, width of each S-box result.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  sequencer can accept a word.
- in_data  input  [1:48]  expanded, key-XORed word; bit 1 is the MSB.
- sbox_req  output  1  lookup strobe to the S-box bank.
- sbox_sel  output  [1:4]  S-box index, 1..8; 0 when idle.
- sbox_in  output  [1:6]  current 6-bit chunk.
- sbox_out  input  [1:4]  bank result for sbox_sel/sbox_in.
- out_valid  output  1  substituted word valid.
- out_ready  input  1  downstream accepts.
- out_data  output  [1:32]  substituted word; nibble k at bits [4k-3:4k].
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: asynchronous, active-low. On assertion, all of these clear to 0: in_ready, sbox_req, sbox_sel, sbox_in, out_valid, out_data, busy, internal data/index registers. State goes to IDLE.
- in_ready goes to 1 on the first clk edge after rst_n deasserts.
- Reset mid-operation aborts the word; no partial output is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, busy=0, sbox_req=0, sbox_sel=0, sbox_in=0.
  - On in_valid&in_ready: latch in_data, idx<=1, go to RUN.
- RUN:
  - in_ready=0, busy=1, sbox_req=1, sbox_sel=idx.
  - sbox_in = latched bits [6*idx-5 : 6*idx].
  - Each cycle, sbox_out is captured into out_data nibble idx at the clock edge, and idx increments.
  - After capturing idx=8, go to DONE.
  - sbox_out is treated as combinational, valid in the same cycle as sbox_sel/sbox_in.
- DONE:
  - out_valid=1 with out_data stable; sbox_req=0, sbox_sel=0.
  - Hold until out_valid&out_ready, then go to IDLE and clear out_valid.
  - out_data keeps its last value after the handshake.
- Latency: out_valid rises 8 cycles after the accepting edge.
- Throughput: one word per 10 cycles with out_ready tied high. The return to IDLE costs one cycle; there is no overlap between words.
- in_valid while busy is ignored; the sequencer never samples in_data outside IDLE.
- out_ready while not out_valid has no effect.
- idx never exceeds 8 and never wraps. An illegal state or idx recovers to IDLE on the next edge.
- Unknown sbox_out is captured as-is; the sequencer performs no checking.

Optional Feature:
- Macro: DES_SBOX_SEQ_PIPE_EN.
- When defined:
  - The S-box bank is treated as registered: sbox_out is valid one cycle after its sbox_sel/sbox_in.
  - RUN issues idx 1..8 on consecutive cycles and captures the result for idx-1 on each edge.
  - One extra drain cycle (sbox_req=0) captures nibble 8.
  - out_valid rises 9 cycles after acceptance.
- When undefined: combinational capture as described above, 8-cycle latency.

Test Plan:
- Zeros word: reset, then in_data=48'h0, out_ready=1, bench models DES S1..S8.
  - Expected: sbox_sel steps 1..8 with sbox_in=0.
  - Expected: out_data=32'hEFA72C4D; out_valid 8 cycles after accept and high for 1 cycle.
- All-ones word: in_data=48'hFFFFFFFFFFFF.
  - Expected: every sbox_in=6'b111111.
  - Expected: out_data=32'hD9CE3DCB.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid.
  - Expected: out_valid and out_data stable, in_ready=0, sbox_req=0.
  - Expected: release gives one transfer, then in_ready=1 on the next cycle.
- Busy input: pulse in_valid with a different in_data during RUN cycle 3.
  - Expected: ignored; out_data matches the first word; in_ready stays 0.
- Reset mid-run: drop rst_n during RUN idx=4.
  - Expected: all outputs 0 immediately; after release in_ready=1 and no out_valid ever appears.
  - Expected: a following zeros word still gives 32'hEFA72C4D.
- With DES_SBOX_SEQ_PIPE_EN and a registered bank model:
  - Expected: zeros word gives 32'hEFA72C4D with out_valid 9 cycles after accept.
